// File: rtl/down_counter_4bit.sv
// Loadable WIDTH-bit down counter / one-shot timer: counts a loaded value down to zero, pulses done.
// Optional periodic reload is enabled by defining DOWN_COUNTER_AUTO_RELOAD_EN.
module down_counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_next;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  // Remembers the last loaded value so DONE can restart the period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= load_val;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Load wins over everything; decrement is only ever applied in RUN with count >= 1.
  always_comb begin
    state_next = state;
    count_next = count;
    if (load) begin
      count_next = load_val;
      state_next = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        RUN: begin
          if (en) begin
            if (count > ONE) begin
              count_next = count - ONE;
            end else begin
              count_next = '0;
              state_next = DONE;
            end
          end
        end
        DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            count_next = reload_q;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
        default: begin
          count_next = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  assign zero = (count == '0);

endmodule
